// File: rtl/maze_sdram_arbiter.sv
// maze_sdram_arbiter: shares one SDRAM controller Avalon-MM slave port between
// the maze-solver engine (requester 0) and the maze/frame reader (requester 1).
// Grants are round-robin and are held until the controller accepts the command.
// Each accepted read pushes its requester id into a small tag FIFO, so that
// in-order read returns can be steered back to the requester that issued them.
module maze_sdram_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [MAX_OUT-1:0] tags_q, tags_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_orphan_q, err_orphan_d;

    logic fifo_full_s, fifo_empty_s;
    logic elig0_s, elig1_s;
    logic busy_s, g_read_s, g_write_s;
    logic accept_s, push_s, pop_s, orphan_s, head_tag_s;

    // Request decode: read wins over write on one requester; reads block on a full tag FIFO.
    always_comb begin
        fifo_full_s  = (count_q == CNT_W'(MAX_OUT));
        fifo_empty_s = (count_q == {CNT_W{1'b0}});
        elig0_s      = (m0_read & ~fifo_full_s) | (m0_write & ~m0_read);
        elig1_s      = (m1_read & ~fifo_full_s) | (m1_write & ~m1_read);
        busy_s       = (state_q == ST_BUSY);
        if (grant_q) begin
            g_read_s  = m1_read;
            g_write_s = m1_write & ~m1_read;
        end else begin
            g_read_s  = m0_read;
            g_write_s = m0_write & ~m0_read;
        end
    end

    // Controller-side command mux; commands are only presented while a grant is held.
    always_comb begin
        if (grant_q) begin
            avm_address    = m1_address;
            avm_writedata  = m1_writedata;
            avm_byteenable = m1_byteenable;
        end else begin
            avm_address    = m0_address;
            avm_writedata  = m0_writedata;
            avm_byteenable = m0_byteenable;
        end
        avm_read  = busy_s & g_read_s;
        avm_write = busy_s & g_write_s;
    end

    // Handshake and tag FIFO strobes; returns with no tag outstanding are orphans.
    always_comb begin
        accept_s   = (avm_read | avm_write) & ~avm_waitrequest;
        push_s     = accept_s & avm_read;
        pop_s      = avm_readdatavalid & ~fifo_empty_s;
        orphan_s   = avm_readdatavalid & fifo_empty_s;
        head_tag_s = tags_q[rd_ptr_q];
    end

    // Requester-side responses: stall everyone except the granted requester in BUSY.
    always_comb begin
        if (busy_s && !grant_q) begin
            m0_waitrequest = avm_waitrequest;
        end else begin
            m0_waitrequest = 1'b1;
        end
        if (busy_s && grant_q) begin
            m1_waitrequest = avm_waitrequest;
        end else begin
            m1_waitrequest = 1'b1;
        end
        m0_readdata      = avm_readdata;
        m1_readdata      = avm_readdata;
        m0_readdatavalid = pop_s & ~head_tag_s;
        m1_readdatavalid = pop_s & head_tag_s;
        err_orphan       = err_orphan_q;
    end

    // Arbitration FSM next state: registered round-robin pick in IDLE, hold grant in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (elig0_s && elig1_s) begin
                    grant_d = ~last_q;
                    state_d = ST_BUSY;
                end else if (elig0_s) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (elig1_s) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else if (!(g_read_s || g_write_s)) begin
                    // Requester withdrew before acceptance: abandon without a tag.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tag FIFO and sticky orphan flag next state; pointers wrap at MAX_OUT (power of 2).
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            tags_d[wr_ptr_q] = grant_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        err_orphan_d = err_orphan_q | orphan_s;
    end

    // State registers; reset leaves m0 favoured on the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            tags_q       <= {MAX_OUT{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            tags_q       <= tags_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

endmodule
